// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered, held grants.
// Optional hold-limit revoke compiled in with RR_ARBITER4_TIMEOUT_EN.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be in 1..255");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_nx;
  logic [1:0] last, last_nx;
  logic [1:0] idx_nx;
  logic       valid_nx;
  logic [1:0] sel;
  logic       sel_hit;
  logic       release_now;

  // Scan last+1 .. last+4; the 2-bit cast wraps the pointer modulo 4.
  always_comb begin
    logic [1:0] cand;
    sel     = '0;
    sel_hit = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!sel_hit && req[cand]) begin
        sel     = cand;
        sel_hit = 1'b1;
      end
    end
  end

  assign release_now = done || !req[grant_idx];

`ifdef RR_ARBITER4_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt, cnt_nx;
  logic       timeout_nx;

  always_comb begin
    state_nx   = state;
    idx_nx     = grant_idx;
    valid_nx   = grant_valid;
    last_nx    = last;
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (sel_hit) begin
          state_nx = GRANT;
          idx_nx   = sel;
          last_nx  = sel;
          valid_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        // Release takes precedence over the hold limit.
        if (release_now) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end else if (cnt == HOLD_LAST) begin
          state_nx   = IDLE;
          valid_nx   = 1'b0;
          timeout_nx = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end
`else
  always_comb begin
    state_nx = state;
    idx_nx   = grant_idx;
    valid_nx = grant_valid;
    last_nx  = last;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (sel_hit) begin
          state_nx = GRANT;
          idx_nx   = sel;
          last_nx  = sel;
          valid_nx = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last        <= '1;
    end else begin
      state       <= state_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      last        <= last_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: stimulus queues expected grants
// (index, length, trailing timeout); a negedge monitor retires them.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] idx;
    int         len;
    logic       to;
  } exp_t;

  exp_t q[$];

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input int len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    q.push_back(e);
  endtask

  // Must be entered in IDLE; leaves the DUT in the IDLE cycle after release.
  task automatic run_grant(input logic [3:0] r, input int hold, input logic [1:0] idx);
    push(idx, hold, 1'b0);
    req = r;
    tick();
    repeat (hold - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   int'(grant_valid), 0);
    chk({tag, "_idx"},     int'(grant_idx),   0);
    chk({tag, "_timeout"}, int'(timeout),     0);
  endtask

  // Monitor: while a grant is shown, its index must match the queue head;
  // when it ends, length and the timeout flag of the following cycle are checked.
  int   len_cnt = 0;
  logic prev_gv = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (grant_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_grant", int'(grant_idx), -1);
      end else begin
        chk("grant_idx", int'(grant_idx), int'(q[0].idx));
      end
      len_cnt++;
    end else if (prev_gv) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("grant_len", len_cnt, e.len);
        chk("grant_end_timeout", int'(timeout), int'(e.to));
      end
      len_cnt = 0;
    end
    prev_gv = (grant_valid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");

    // Single request straight out of reset.
    rst_n = 1'b1;
    push(2'd2, 1, 1'b0);
    req = 4'b0100;
    tick();
    chk("single_valid", int'(grant_valid), 1);
    chk("single_idx",   int'(grant_idx),   2);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    chk("release_valid",    int'(grant_valid), 0);
    chk("idle_idx_held",    int'(grant_idx),   2);
    chk("release_timeout",  int'(timeout),     0);
    tick();

    // Reset in IDLE restores the pointer; then full rotation.
    rst_n = 1'b0;
    tick();
    chk_reset_vals("reset2");
    rst_n = 1'b1;
    run_grant(4'b1111, 2, 2'd0);
    run_grant(4'b1111, 1, 2'd1);
    run_grant(4'b1111, 3, 2'd2);
    run_grant(4'b1111, 1, 2'd3);
    run_grant(4'b1111, 1, 2'd0);
    req = 4'b0000;
    tick();

    // Wrap and skip.
    run_grant(4'b1000, 2, 2'd3);
    run_grant(4'b1010, 1, 2'd1);
    run_grant(4'b0001, 1, 2'd0);
    run_grant(4'b1100, 1, 2'd2);
    req = 4'b0000;
    tick();

    // Request drop with other bits toggling during the grant.
    push(2'd2, 2, 1'b0);
    req = 4'b0100;
    tick();
    req = 4'b0101;
    tick();
    req = 4'b1011;
    tick();
    req = 4'b0000;
    chk("drop_valid",   int'(grant_valid), 0);
    chk("drop_timeout", int'(timeout),     0);
    tick();

    // done in IDLE is ignored: no grant without req, grant still issued with req.
    done = 1'b1;
    tick();
    chk("idle_done_valid", int'(grant_valid), 0);
    push(2'd0, 1, 1'b0);
    req = 4'b0001;
    tick();
    chk("idle_done_grant", int'(grant_valid), 1);
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tick();

`ifdef RR_ARBITER4_TIMEOUT_EN
    // HOLD_MAX=4: forced revoke, then release coinciding with the limit.
    push(2'd0, 4, 1'b1);
    push(2'd0, 4, 1'b0);
    req = 4'b0001;
    repeat (4) tick();
    tick();
    chk("revoke_valid",   int'(grant_valid), 0);
    chk("revoke_timeout", int'(timeout),     1);
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    chk("limit_release_timeout", int'(timeout), 0);
    tick();
`else
    run_grant(4'b0001, 120, 2'd0);
    req = 4'b0000;
    tick();
`endif

    // Mid-grant reset: pointer returns to 3, so next grant is 0.
    push(2'd3, 2, 1'b0);
    req = 4'b1000;
    tick();
    tick();
    rst_n = 1'b0;
    req   = 4'b1001;
    tick();
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    run_grant(4'b1001, 1, 2'd0);
    req = 4'b0000;
    tick();
    tick();

    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that produces the 2-bit grant index consumed by the 2-to-4 `decoder` stage. Each grant is registered and held until the requester releases it. `grant_idx` connects directly to the decoder `in` port, and `grant_valid` qualifies the decoder's one-hot output. Fairness is round-robin: the last granted requester becomes lowest priority.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles a grant may be held when the timeout feature is compiled in; legal range 1..255.
- `clk`  input  1  system clock; all logic is clocked on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  4  request vector; bit i is requester i.
- `done`  input  1  release strobe from the current grant holder.
- `grant_idx`  output  2  index of the granted requester; this is the decoder input.
- `grant_valid`  output  1  grant active; qualifies `grant_idx`.
- `timeout`  output  1  one-cycle pulse marking a grant revoked by the hold limit.

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Reset values (`rst_n`=0 at an edge):
  - state = IDLE, `grant_idx` = 2'b00, `grant_valid` = 0, `timeout` = 0.
  - Priority pointer `last` = 2'b11, so requester 0 has top priority first.
  - Hold counter = 0.
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise select the first set bit scanning `last+1`, `last+2`, `last+3`, `last`, modulo 4 with 2-bit wrap.
  - At the next edge: `grant_idx` = selected index, `last` = selected index, `grant_valid` = 1, counter = 0, state = GRANT.
- GRANT:
  - Release condition: `done`=1, or `req[grant_idx]`=0.
  - On release, at the next edge: state = IDLE, `grant_valid` = 0.
  - With no release, the counter increments each cycle.
- `grant_idx` holds its last value while in IDLE, so the decoder input never glitches.
- Requests that change during GRANT have no effect on the current grant. Only IDLE arbitrates.
- Timeout: when the counter == `HOLD_MAX`-1 and there is no release, the next edge forces IDLE, clears `grant_valid`, and sets `timeout` = 1 for exactly one cycle.
- If release and the hold limit occur in the same cycle, release wins and `timeout` stays 0.
- Counter width is 8 bits. It saturates and never wraps.

## Timing
- Request-to-grant latency: 1 cycle, from the edge that samples `req` in IDLE to `grant_valid`=1.
- There is always exactly one IDLE cycle (`grant_valid`=0) between consecutive grants, including back-to-back grants to the same requester.
- Maximum grant length with timeout enabled: `HOLD_MAX` cycles of `grant_valid`=1.
- `timeout` is high only during the IDLE cycle that follows a forced revoke.
- Reset asserted mid-grant: reset values apply at that edge and `last` returns to 2'b11. The counter and `timeout` clear.
- `done` sampled while in IDLE is ignored.

## Configuration
- Macro: `RR_ARBITER4_TIMEOUT_EN`.
- Defined: the hold counter and timeout revoke operate as described above.
- Undefined:
  - Counter logic is removed and `timeout` is tied to 0.
  - A grant lasts until release only, with no upper bound.
  - `HOLD_MAX` is ignored.

## Test plan
- Reset then single request: release reset with `req`=4'b0100 → one cycle later `grant_idx`=2, `grant_valid`=1. Assert `done` for one cycle → `grant_valid`=0 at the next edge.
- Rotation: hold `req`=4'b1111 and pulse `done` on every grant → grants run 0,1,2,3,0 with one IDLE cycle between each.
- Wrap and skip: with `last`=3, `req`=4'b1010 → grant 1. Then `req`=4'b0001 → grant 0, with the pointer wrapping correctly.
- Request drop: grant 2, then drop `req[2]` without `done` → `grant_valid`=0 next edge and `timeout`=0. Bits of `req` changing during GRANT leave `grant_idx` unchanged.
- Timeout (macro defined, `HOLD_MAX`=4): hold `req`=4'b0001 and never assert `done` → `grant_valid`=1 for exactly 4 cycles, then `timeout`=1 for 1 cycle, then re-grant 0. Asserting `done` in the 4th cycle → `timeout` stays 0. With the macro undefined → grant holds for more than 100 cycles and `timeout` stays 0.
- Mid-grant reset: grant 3 active, pull `rst_n` low for 1 cycle with `req`=4'b1001 → outputs go to reset values. Next grant is 0, not 3.
